// File: rtl/rl_fifo_rdstream_pkg.sv
// Shared constants for the FIFO-to-stream read adapter.
package rl_fifo_rdstream_pkg;

  // Depth of the output skid buffer; reads are throttled so that
  // buffered words plus the word in flight never exceed this.
  localparam logic [1:0] RDS_BUF_DEPTH = 2'd2;

endpackage

// File: rtl/rl_fifo_rdstream.sv
// Turns a registered-output FIFO read port into a valid/ready stream
// using a 2-entry buffer that absorbs the one-cycle read latency.
module rl_fifo_rdstream
  import rl_fifo_rdstream_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  output logic                 fifo_rdena_o,
  input  logic [DATA_SIZE-1:0] fifo_q_i,
  input  logic                 fifo_empty_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATA_SIZE-1:0] q_o,
  output logic [CNT_SIZE-1:0]  cnt_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                 occ_q, occ_d;
  logic                 inflight_q;
  logic [DATA_SIZE-1:0] head_q, tail_q;
  logic [CNT_SIZE-1:0]  cnt_q;
  logic [1:0]           occ_bits;
  logic [1:0]           pending;
  logic                 xfer;
  logic                 wr;

  assign occ_bits = occ_q;
  assign pending  = occ_bits + {1'b0, inflight_q};
  assign xfer     = valid_o & ready_i;
  assign wr       = inflight_q;

  // Gated by rst_i so the read strobe drops the moment reset is applied.
  assign fifo_rdena_o = ~rst_i & ~clr_i & ~fifo_empty_i &
                        ((pending < RDS_BUF_DEPTH) | xfer);

  assign valid_o = (occ_q != OCC_EMPTY);
  assign q_o     = head_q;
  assign cnt_o   = cnt_q;
  assign busy_o  = (occ_q != OCC_EMPTY) | inflight_q;

  always_comb begin
    occ_d = occ_q;
    if (wr && !xfer) begin
      case (occ_q)
        OCC_EMPTY: occ_d = OCC_ONE;
        default:   occ_d = OCC_TWO;
      endcase
    end else if (xfer && !wr) begin
      case (occ_q)
        OCC_TWO: occ_d = OCC_ONE;
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else if (clr_i) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rdena_o;
      if (xfer) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Data registers carry no reset; occupancy alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (xfer && wr) begin
      if (occ_q == OCC_TWO) begin
        head_q <= tail_q;
        tail_q <= fifo_q_i;
      end else begin
        head_q <= fifo_q_i;
      end
    end else if (xfer) begin
      head_q <= tail_q;
    end else if (wr) begin
      if (occ_q == OCC_EMPTY) head_q <= fifo_q_i;
      else                    tail_q <= fifo_q_i;
    end
  end

endmodule

// File: tb/tb_rl_fifo_rdstream.sv
// Directed bench for rl_fifo_rdstream with a registered-output FIFO model.
module tb_rl_fifo_rdstream;

  logic        clk = 1'b0;
  logic        rst, clr, ready;
  logic        rdena, rdena4, fifo_empty;
  logic [31:0] fifo_q;
  logic        valid, busy, valid4, busy4;
  logic [31:0] q, q4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:4095];
  int wp = 0;
  int rp = 0;
  int rd_cnt = 0;
  int xf_cnt = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);

  // Registered-output FIFO: data appears the cycle after an accepted read.
  always @(posedge clk) begin
    if (rdena && !fifo_empty) begin
      fifo_q <= mem[rp % 4096];
      rp     <= rp + 1;
      rd_cnt <= rd_cnt + 1;
    end
    if (valid && ready) xf_cnt <= xf_cnt + 1;
  end

  rl_fifo_rdstream #(.DATA_SIZE(32), .CNT_SIZE(16)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .fifo_rdena_o(rdena),
    .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty), .valid_o(valid),
    .ready_i(ready), .q_o(q), .cnt_o(cnt), .busy_o(busy)
  );

  // Same stimulus, narrow counter: only its cnt_o is of interest.
  rl_fifo_rdstream #(.DATA_SIZE(32), .CNT_SIZE(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .fifo_rdena_o(rdena4),
    .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty), .valid_o(valid4),
    .ready_i(ready), .q_o(q4), .cnt_o(cnt4), .busy_o(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wp % 4096] = d;
    wp = wp + 1;
  endtask

  logic [31:0] exp_q[$];
  int rd_base, xf_base, idx, cyc, n_before;

  initial begin
    rst = 1'b1; clr = 1'b0; ready = 1'b0;
    #2;
    push(32'hdead);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdena", rdena, 0);
    chk("rst_cnt", cnt, 0);
    wp = rp;
    tick();
    rst = 1'b0;
    tick();

    // Four words, sink always ready: N+2 latency then one per cycle.
    ready = 1'b1;
    push(32'h11); push(32'h12); push(32'h13); push(32'h14);
    #1;
    chk("burst_rdena", rdena, 1);
    chk("burst_valid_n", valid, 0);
    tick();
    chk("burst_valid_n1", valid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("burst_valid", valid, 1);
      chk("burst_q", q, 32'h11 + k);
      tick();
    end
    chk("burst_valid_end", valid, 0);
    chk("burst_busy_end", busy, 0);
    chk("burst_cnt", cnt, 4);

    // Three words with the sink stalled: only two reads may be issued.
    ready = 1'b0;
    rd_base = rd_cnt;
    push(32'h11); push(32'h12); push(32'h13);
    for (int k = 0; k < 10; k++) tick();
    chk("stall_reads", rd_cnt - rd_base, 2);
    chk("stall_valid", valid, 1);
    chk("stall_q", q, 32'h11);
    chk("stall_rdena", rdena, 0);
    chk("stall_busy", busy, 1);
    tick();
    chk("stall_q_hold", q, 32'h11);
    ready = 1'b1;
    #1;
    chk("unstall_rdena", rdena, 1);
    chk("unstall_q0", q, 32'h11);
    tick();
    chk("unstall_q1", q, 32'h12);
    tick();
    chk("unstall_q2", q, 32'h13);
    tick();
    chk("unstall_empty", valid, 0);
    chk("unstall_cnt", cnt, 7);

    // Flush while a read is returning: that word must vanish.
    push(32'h55);
    #1;
    chk("clr_rdena_pre", rdena, 1);
    tick();
    clr = 1'b1;
    #1;
    chk("clr_gates_rdena_src", busy, 1);
    tick();
    chk("clr_valid", valid, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_busy", busy, 0);
    push(32'h66);
    #1;
    chk("clr_blocks_rdena", rdena, 0);
    clr = 1'b0;
    #1;
    chk("clr_release_rdena", rdena, 1);
    tick();
    chk("clr_drop_valid", valid, 0);
    tick();
    chk("post_clr_valid", valid, 1);
    chk("post_clr_q", q, 32'h66);
    tick();
    chk("post_clr_cnt", cnt, 1);

    // 17 words after a flush: narrow counter wraps to 1.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 17; k++) push(32'h100 + k);
    cyc = 0;
    do begin tick(); cyc++; end while ((!fifo_empty || busy) && cyc < 200);
    chk("wrap_timeout", cyc < 200, 1);
    chk("wrap_cnt16", cnt, 17);
    chk("wrap_cnt4", cnt4, 1);

    // Random sink backpressure over 1000 words.
    rd_base = rd_cnt;
    xf_base = xf_cnt;
    n_before = fails;
    for (int k = 0; k < 1000; k++) begin
      exp_q.push_back($urandom);
      push(exp_q[k]);
    end
    idx = 0;
    cyc = 0;
    while (idx < 1000 && cyc < 6000) begin
      ready = ($urandom_range(0, 1) == 1);
      #1;
      if (valid && ready) begin
        if (q !== exp_q[idx]) chk("rand_q", q, exp_q[idx]);
        idx++;
      end
      if ((rd_cnt - rd_base) - (xf_cnt - xf_base) > 2)
        chk("rand_occ", (rd_cnt - rd_base) - (xf_cnt - xf_base), 2);
      tick();
      cyc++;
    end
    chk("rand_errs", fails - n_before, 0);
    chk("rand_count", idx, 1000);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("rand_no_extra_valid", valid, 0);
    chk("rand_fifo_drained", fifo_empty, 1);

    // Asynchronous reset with the buffer full.
    push(32'h21); push(32'h22); push(32'h23);
    for (int k = 0; k < 5; k++) tick();
    chk("full_valid", valid, 1);
    chk("full_q", q, 32'h21);
    chk("full_rdena", rdena, 0);
    ready = 1'b1;
    #1;
    chk("full_xfer_rdena", rdena, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdena", rdena, 0);
    chk("arst_cnt", cnt, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rdena", rdena, 1);
    tick();
    chk("post_rst_valid_n1", valid, 0);
    tick();
    chk("post_rst_valid", valid, 1);
    chk("post_rst_q", q, 32'h23);
    tick();
    chk("post_rst_done", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rl_fifo_rdstream.md
RL_FIFO_RDSTREAM -- requirements
Module: rl_fifo_rdstream

Interface
REQ-001 Parameter DATA_SIZE, default 32, sets the data width of the FIFO read port and the stream port.
REQ-002 Parameter CNT_SIZE, default 16, sets the width of the delivered-word counter.
REQ-003 clk_i  input  1  single clock; all logic is rising-edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 clr_i  input  1  synchronous flush: empties the buffer, drops in-flight data and zeroes the counter.
REQ-006 fifo_rdena_o  output  1  read request to the FIFO read port.
REQ-007 fifo_q_i  input  DATA_SIZE  FIFO read data; valid one cycle after an accepted fifo_rdena_o.
REQ-008 fifo_empty_i  input  1  FIFO empty flag.
REQ-009 valid_o  output  1  stream data valid.
REQ-010 ready_i  input  1  stream sink ready.
REQ-011 q_o  output  DATA_SIZE  stream data.
REQ-012 cnt_o  output  CNT_SIZE  number of words transferred on the stream, modulo 2^CNT_SIZE.
REQ-013 busy_o  output  1  high when the buffer is occupied or a read is in flight.

Function
REQ-014 The block shall assume a FIFO with a registered output: fifo_rdena_o=1 with fifo_empty_i=0 in cycle N returns a word on fifo_q_i in cycle N+1.
REQ-015 The block shall hold a 2-entry output buffer and an occupancy state of EMPTY, ONE or TWO, plus an inflight bit.
REQ-016 fifo_rdena_o shall be asserted iff fifo_empty_i=0 and (occupancy + inflight < 2, or a stream transfer occurs in the same cycle) and clr_i=0.
REQ-017 The inflight bit shall be set in the cycle after fifo_rdena_o is asserted, and cleared otherwise.
REQ-018 While inflight=1, the word on fifo_q_i shall be written into the buffer at the tail.
REQ-019 valid_o shall equal (occupancy != EMPTY), and q_o shall always present the head entry.
REQ-020 A transfer occurs when valid_o=1 and ready_i=1; the head is then removed and the next entry, if any, becomes the head in the following cycle.
REQ-021 Occupancy transitions: write only gives +1, transfer only gives -1, write and transfer together give no change; the buffer shall never exceed TWO.
REQ-022 Throughput: with fifo_empty_i=0 and ready_i=1 held, the block shall sustain one transfer per cycle after a 2-cycle initial latency.
REQ-023 Latency: from the first fifo_rdena_o at cycle N into an empty block, valid_o shall be 1 at cycle N+2.
REQ-024 With ready_i=0, q_o and valid_o shall be held stable until a transfer occurs.
REQ-025 cnt_o shall increment by 1 on each transfer and wrap from 2^CNT_SIZE-1 to 0.
REQ-026 clr_i=1 shall, at the next edge, set occupancy to EMPTY, set inflight to 0 and set cnt_o to 0; a word returning in the cycle after clr_i shall be discarded.
REQ-027 busy_o shall equal (occupancy != EMPTY) or inflight.

Reset
REQ-028 On rst_i=1 the following shall hold immediately, independent of clk_i: occupancy=EMPTY, inflight=0, valid_o=0, fifo_rdena_o=0, cnt_o=0, busy_o=0.
REQ-029 Buffer data registers shall not be reset; q_o is undefined while valid_o=0.
REQ-030 Reset asserted mid-operation shall discard all buffered and in-flight data; the first read after reset deassertion shall follow REQ-016.

Structure
REQ-031 No shared package is required; the occupancy encoding shall be a local enum within the module.
REQ-032 The block shall be a single module with no sub-modules; the testbench shall pair it with rl_scfifo configured with REGISTERED_OUTPUT="YES".

Verification
REQ-033 Write 4 words 0x11..0x14 into the FIFO, ready_i=1: q_o delivers 0x11,0x12,0x13,0x14 on consecutive cycles; cnt_o=4; busy_o falls afterwards.
REQ-034 Write 3 words, ready_i=0 for 10 cycles: exactly 2 reads are issued, valid_o=1 and q_o=0x11 stable; when ready_i=1 all 3 words are delivered in order.
REQ-035 Drive ready_i with a random 50% pattern over 1000 words: output order matches input order, no loss or duplication, occupancy never exceeds 2.
REQ-036 Assert clr_i in the cycle after fifo_rdena_o: the returning word is dropped, valid_o=0 and cnt_o=0 next cycle.
REQ-037 Set CNT_SIZE=4 and transfer 17 words: cnt_o=1.
REQ-038 Assert rst_i asynchronously with occupancy TWO: valid_o, busy_o and fifo_rdena_o go to 0 before the next clock edge.
